event_fifo_irq: RTL and testbench
=================================

// Module: event_fifo_irq
// PURPOSE
//  Parametrised event FIFO with hysteretic threshold interrupt, sitting between the
//  pixel event path and the SPI regfile. Replaces the fixed-depth FIFO: width and depth
//  are parameters, plus sticky overflow/underflow flags and a synchronous soft reset.
//  Thresholds, soft reset and flag clear are driven from regfile bytes; numel is read back over SPI.
// PARAMETERS
//  DWIDTH  32  event word width in bits (>=1)
//  DEPTH   8   entries; power of two, >=2
//  CWIDTH  $clog2(DEPTH)+1 (localparam)  count/threshold width; holds 0..DEPTH
// PORTS
//  clk                  in   1       system clock
//  rst_n                in   1       asynchronous active-low reset
//  soft_rst_n           in   1       synchronous active-low FIFO clear (regfile fifo_rst_n)
//  wr_en                in   1       push wr_data this cycle
//  wr_data              in   DWIDTH  event word
//  rd_en                in   1       pop one entry this cycle
//  rd_data              out  DWIDTH  popped word, registered
//  rd_valid             out  1       rd_data updated this cycle (1-cycle pulse)
//  full                 out  1       numel == DEPTH
//  empty                out  1       numel == 0
//  numel                out  CWIDTH  current occupancy
//  irq_assert_thresh    in   CWIDTH  irq sets when numel >= this; 0 disables irq
//  irq_deassert_thresh  in   CWIDTH  irq clears when numel <= this
//  irq                  out  1       registered interrupt, active high
//  clr_flags            in   1       synchronous clear of overflow/underflow
//  overflow             out  1       sticky: write dropped while full
//  underflow            out  1       sticky: read requested while empty
// BEHAVIOUR
//  - rst_n low: pointers, numel, irq, rd_valid, overflow, underflow = 0; rd_data = 0;
//    empty = 1, full = 0. Storage array not reset.
//  - Write accepted iff wr_en && (!full || rd_en); data stored at wr_ptr, wr_ptr++ mod DEPTH.
//  - Read accepted iff rd_en && !empty; rd_data <= mem[rd_ptr] next edge, rd_valid = 1
//    that following cycle; rd_ptr++ mod DEPTH. Read latency 1 cycle. rd_data holds otherwise.
//  - Simultaneous accepted read+write: numel unchanged. Full + both: both accepted, the
//    read returns the oldest entry. Empty + both: write accepted, read ignored, underflow set.
//  - numel: +1 write only, -1 read only; registered, same-edge as pointer update.
//  - wr_en && full && !rd_en: data dropped, overflow <= 1. rd_en && empty: underflow <= 1.
//  - clr_flags clears both flags; a same-cycle set event wins over clr_flags.
//  - irq (registered, evaluated on current numel):
//      irq_assert_thresh == 0          -> irq <= 0
//      !irq && numel >= assert_thresh  -> irq <= 1
//      irq && numel <= deassert_thresh && numel < assert_thresh -> irq <= 0
//    deassert >= assert degenerates to a level compare (numel >= assert). assert > DEPTH never fires.
//    irq lags numel by one cycle.
//  - soft_rst_n low (sampled on clk): next state same as rst_n, except rd_data holds;
//    wr_en/rd_en that cycle ignored, no flag set. Takes priority over all other updates.
//  - Async rst_n mid-operation: immediate clear; first push after release is accepted normally.
// TESTING
//  1 Reset: after rst_n release -> empty=1, full=0, numel=0, irq=0, both flags 0.
//  2 Push 0xA0..0xA7 (8 writes) -> full=1, numel=8; 9th write -> dropped, overflow=1;
//    8 reads -> rd_data 0xA0..0xA7 in order, each 1 cycle after rd_en, then empty=1.
//  3 Thresholds assert=6, deassert=2: push 6 -> irq rises 1 cycle after numel=6; pop
//    to numel=3 -> irq stays 1; pop to 2 -> irq falls next cycle.
//  4 Full + simultaneous rd_en/wr_en (0xBB) -> numel stays 8, oldest word read, 0xBB
//    read last; empty + both -> write kept, numel=1, underflow=1; clr_flags -> flags 0.
//  5 With 5 entries and irq high, pulse soft_rst_n 1 cycle -> numel=0, irq=0, flags 0,
//    rd_data unchanged; next push/pop round-trips correctly. assert=0 -> irq never set.
//  6 Wrap: 3 passes of 8 pushes/8 pops with DEPTH=8 and DEPTH=16 -> data order and
//    numel correct across pointer wrap; assert/deassert = 0xFFF/0x000 equivalents stay consistent.

Source files
------------

// File: rtl/event_fifo_irq.sv
// Event FIFO between the pixel event path and the SPI regfile, with a hysteretic
// occupancy interrupt, sticky overflow/underflow flags and a synchronous soft clear.
module event_fifo_irq #(
    parameter int  DWIDTH = 32,
    parameter int  DEPTH  = 8,
    localparam int CWIDTH = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              soft_rst_n,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [CWIDTH-1:0] numel,
    input  logic [CWIDTH-1:0] irq_assert_thresh,
    input  logic [CWIDTH-1:0] irq_deassert_thresh,
    output logic              irq,
    input  logic              clr_flags,
    output logic              overflow,
    output logic              underflow
);

    localparam int AWIDTH = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_set;
    logic              udf_set;
    logic              irq_next;

    assign full    = (numel == CWIDTH'(DEPTH));
    assign empty   = (numel == '0);
    // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
    assign wr_acc  = wr_en && (!full || rd_en);
    assign rd_acc  = rd_en && !empty;
    assign ovf_set = wr_en && full && !rd_en;
    assign udf_set = rd_en && empty;

    // Hysteresis: set at the assert level, clear only once at/below deassert and below assert.
    always_comb begin
        irq_next = irq;
        if (irq_assert_thresh == '0) begin
            irq_next = 1'b0;
        end else if (!irq && (numel >= irq_assert_thresh)) begin
            irq_next = 1'b1;
        end else if (irq && (numel <= irq_deassert_thresh) && (numel < irq_assert_thresh)) begin
            irq_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (soft_rst_n && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            numel     <= '0;
            irq       <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!soft_rst_n) begin
            // rd_data deliberately keeps the last popped word across a soft clear
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            numel     <= '0;
            irq       <= 1'b0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            irq      <= irq_next;
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AWIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + AWIDTH'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   numel <= numel + CWIDTH'(1);
                2'b01:   numel <= numel - CWIDTH'(1);
                default: numel <= numel;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (udf_set) begin
                underflow <= 1'b1;
            end else if (clr_flags) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_event_fifo_irq.sv
// Bench for event_fifo_irq: DEPTH=8 and DEPTH=16 instances on shared stimulus,
// each checked every cycle against a queue-level model plus directed literal checks.
module tb_event_fifo_irq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        soft_rst_n = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_flags = 1'b0;
    logic [31:0] wr_data = '0;
    logic [3:0]  ath8 = '0, dth8 = '0;
    logic [4:0]  ath16 = '0, dth16 = '0;

    logic [31:0] rdd8, rdd16;
    logic        rdv8, rdv16, full8, full16, empty8, empty16;
    logic        irq8, irq16, ovf8, ovf16, udf8, udf16;
    logic [3:0]  n8;
    logic [4:0]  n16;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // model state: index 0 = DEPTH 8, index 1 = DEPTH 16; m_q[k][0] is the oldest entry
    int          m_depth [2] = '{8, 16};
    int          m_cnt [2];
    logic [31:0] m_q [2][17];
    logic [31:0] m_rdd [2];
    bit          m_rdv [2], m_irq [2], m_ovf [2], m_udf [2];

    always #5 clk = ~clk;

    event_fifo_irq #(.DWIDTH(32), .DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .soft_rst_n(soft_rst_n),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rdd8), .rd_valid(rdv8), .full(full8), .empty(empty8), .numel(n8),
        .irq_assert_thresh(ath8), .irq_deassert_thresh(dth8), .irq(irq8),
        .clr_flags(clr_flags), .overflow(ovf8), .underflow(udf8)
    );

    event_fifo_irq #(.DWIDTH(32), .DEPTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .soft_rst_n(soft_rst_n),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rdd16), .rd_valid(rdv16), .full(full16), .empty(empty16), .numel(n16),
        .irq_assert_thresh(ath16), .irq_deassert_thresh(dth16), .irq(irq16),
        .clr_flags(clr_flags), .overflow(ovf16), .underflow(udf16)
    );

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s depth%0d actual=%h expected=%h t=%0t", nm, m_depth[k], act, exp, $time);
        end
    endtask

    task automatic mreset(input int k, input bit keep_rdd);
        m_cnt[k] = 0;
        m_rdv[k] = 0;
        m_irq[k] = 0;
        m_ovf[k] = 0;
        m_udf[k] = 0;
        if (!keep_rdd) m_rdd[k] = '0;
    endtask

    task automatic mstep(input int k, input int a, input int d);
        int c;
        bit rok, wok;
        c = m_cnt[k];
        if (!soft_rst_n) begin
            mreset(k, 1'b1);
            return;
        end
        if (a == 0) m_irq[k] = 0;
        else if (!m_irq[k] && c >= a) m_irq[k] = 1;
        else if (m_irq[k] && c <= d && c < a) m_irq[k] = 0;
        rok = rd_en && (c > 0);
        wok = wr_en && ((c < m_depth[k]) || rd_en);
        if (wr_en && c == m_depth[k] && !rd_en) m_ovf[k] = 1;
        else if (clr_flags) m_ovf[k] = 0;
        if (rd_en && c == 0) m_udf[k] = 1;
        else if (clr_flags) m_udf[k] = 0;
        m_rdv[k] = rok;
        if (rok) begin
            m_rdd[k] = m_q[k][0];
            for (int i = 0; i < 16; i++) m_q[k][i] = m_q[k][i+1];
            c--;
        end
        if (wok) begin
            m_q[k][c] = wr_data;
            c++;
        end
        m_cnt[k] = c;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreset(0, 1'b0);
            mreset(1, 1'b0);
        end else begin
            mstep(0, int'(ath8), int'(dth8));
            mstep(1, int'(ath16), int'(dth16));
        end
    end

    task automatic cmp(input int k, input logic [31:0] rdd, input logic rdv, input logic full,
                       input logic empty, input int n, input logic irq, input logic ovf, input logic udf);
        chk("numel", k, n, m_cnt[k]);
        chk("full", k, full, m_cnt[k] == m_depth[k]);
        chk("empty", k, empty, m_cnt[k] == 0);
        chk("rd_valid", k, rdv, m_rdv[k]);
        chk("rd_data", k, rdd, m_rdd[k]);
        chk("irq", k, irq, m_irq[k]);
        chk("overflow", k, ovf, m_ovf[k]);
        chk("underflow", k, udf, m_udf[k]);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp(0, rdd8, rdv8, full8, empty8, int'(n8), irq8, ovf8, udf8);
            cmp(1, rdd16, rdv16, full16, empty16, int'(n16), irq16, ovf16, udf16);
        end
    end

    // Apply one cycle of inputs at a negedge; returns at the following negedge.
    task automatic drive(input bit w, input logic [31:0] d, input bit r, input bit c, input bit s);
        wr_en = w;
        wr_data = d;
        rd_en = r;
        clr_flags = c;
        soft_rst_n = s;
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] d);
        drive(1, d, 0, 0, 1);
    endtask

    task automatic pop();
        drive(0, 0, 1, 0, 1);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic set_thr(input int a8, input int d8, input int a16, input int d16);
        ath8 = 4'(a8);
        dth8 = 4'(d8);
        ath16 = 5'(a16);
        dth16 = 5'(d16);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_empty", 0, empty8, 1);
        chk("rst_full", 0, full8, 0);
        chk("rst_numel", 0, n8, 0);
        chk("rst_irq", 1, irq16, 0);
        chk("rst_flags", 0, {ovf8, udf8}, 0);

        for (int i = 0; i < 8; i++) push(32'hA0 + i);
        chk("t2_full", 0, full8, 1);
        chk("t2_numel", 0, n8, 8);
        push(32'hA8);
        chk("t2_overflow", 0, ovf8, 1);
        chk("t2_numel_drop", 0, n8, 8);
        for (int i = 0; i < 8; i++) begin
            pop();
            chk("t2_rd_valid", 0, rdv8, 1);
            chk("t2_rd_data", 0, rdd8, 32'hA0 + i);
        end
        chk("t2_empty", 0, empty8, 1);
        pop();

        set_thr(6, 2, 6, 2);
        for (int i = 0; i < 6; i++) push(32'h60 + i);
        chk("t3_irq_lag", 0, irq8, 0);
        idle();
        chk("t3_irq_rise", 0, irq8, 1);
        repeat (3) pop();
        chk("t3_numel3", 0, n8, 3);
        chk("t3_irq_hold", 0, irq8, 1);
        pop();
        chk("t3_irq_at2", 0, irq8, 1);
        idle();
        chk("t3_irq_fall", 0, irq8, 0);
        repeat (2) pop();

        for (int i = 0; i < 8; i++) push(32'hC0 + i);
        drive(1, 32'hBB, 1, 0, 1);
        chk("t4_numel", 0, n8, 8);
        chk("t4_oldest", 0, rdd8, 32'hC0);
        for (int i = 1; i < 9; i++) begin
            pop();
            chk("t4_order", 0, rdd8, (i == 8) ? 32'hBB : 32'hC0 + i);
        end
        drive(1, 32'hDD, 1, 0, 1);
        chk("t4_empty_both_numel", 0, n8, 1);
        chk("t4_underflow", 0, udf8, 1);
        chk("t4_no_rd_valid", 0, rdv8, 0);
        drive(0, 0, 0, 1, 1);
        chk("t4_clr", 0, {ovf8, udf8}, 0);
        pop();
        chk("t4_dd", 0, rdd8, 32'hDD);

        set_thr(4, 1, 4, 1);
        pop();
        for (int i = 0; i < 5; i++) push(32'hE0 + i);
        idle();
        chk("t5_irq_high", 0, irq8, 1);
        chk("t5_udf_set", 0, udf8, 1);
        drive(1, 32'h77, 1, 0, 0);
        chk("t5_soft_numel", 0, n8, 0);
        chk("t5_soft_irq", 0, irq8, 0);
        chk("t5_soft_flags", 0, {ovf8, udf8}, 0);
        chk("t5_soft_rd_data", 0, rdd8, 32'hDD);
        push(32'hE1);
        chk("t5_push_after", 0, n8, 1);
        pop();
        chk("t5_roundtrip", 0, rdd8, 32'hE1);
        set_thr(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) push(32'hF0 + i);
        idle();
        chk("t5_assert0_irq", 0, irq8, 0);
        repeat (8) pop();

        set_thr(15, 0, 31, 0);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) push(32'h100 * (p + 1) + i);
            chk("t6_numel8", 0, n8, 8);
            chk("t6_numel16", 1, n16, 8);
            for (int i = 0; i < 8; i++) begin
                pop();
                chk("t6_data8", 0, rdd8, 32'h100 * (p + 1) + i);
                chk("t6_data16", 1, rdd16, 32'h100 * (p + 1) + i);
            end
            chk("t6_irq", 0, {irq8, irq16}, 0);
        end

        for (int i = 0; i < 3; i++) push(32'h30 + i);
        idle();
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("arst_numel", 0, n8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        push(32'h55);
        chk("arst_push", 0, n8, 1);
        pop();
        chk("arst_pop", 0, rdd8, 32'h55);

        for (int i = 0; i < 3000; i++) begin
            int wp;
            if (i % 64 == 0)
                set_thr($urandom_range(0, 10), $urandom_range(0, 10),
                        $urandom_range(0, 18), $urandom_range(0, 18));
            wp = ((i / 80) % 2 == 0) ? 75 : 30;
            drive($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 149) != 0);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
